// File: rtl/his_pkg.sv
// his_pkg: definitions shared by the histogram builder and the histogram reader.
//   his_rd_state_e : readout FSM states (IDLE, READ, DRAIN)
//   PIX_W / BIN_W  : index widths for the default 4-pixel, 64-bin configuration
//   his_idx_w()    : index width for a given element count (minimum 1 bit)
//   his_addr()     : packs {pix, bin} into a RAM address
package his_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2
   } his_rd_state_e;

   localparam int unsigned PIXEL_NUM_DEF = 4;
   localparam int unsigned BIN_NUM_DEF   = 64;

   function automatic int unsigned his_idx_w(input int unsigned n);
      return (n > 1) ? unsigned'($clog2(n)) : 1;
   endfunction

   localparam int unsigned PIX_W = his_idx_w(PIXEL_NUM_DEF);
   localparam int unsigned BIN_W = his_idx_w(BIN_NUM_DEF);

   // Bin index occupies the low bin_w bits; pixel index sits above it.
   function automatic logic [31:0] his_addr(input logic [31:0] pix,
                                            input logic [31:0] bin,
                                            input int unsigned bin_w);
      return (pix << bin_w) | bin;
   endfunction

endpackage

// File: rtl/his_reader_if.sv
// his_reader_if: bin stream from the histogram reader to the DF stage.
//   bin_valid/bin_ready : handshake
//   bin_data            : bin count
//   bin_idx / bin_pix   : bin and pixel index of the beat
//   bin_last            : last bin of the pixel
// Modports: master (reader side), slave (consumer side).
interface his_reader_if #(
   parameter int unsigned CNT_W = 16,
   parameter int unsigned PIX_W = 2,
   parameter int unsigned BIN_W = 6
);
   logic             bin_valid;
   logic             bin_ready;
   logic [CNT_W-1:0] bin_data;
   logic [BIN_W-1:0] bin_idx;
   logic [PIX_W-1:0] bin_pix;
   logic             bin_last;

   modport master (
      output bin_valid, bin_data, bin_idx, bin_pix, bin_last,
      input  bin_ready
   );

   modport slave (
      input  bin_valid, bin_data, bin_idx, bin_pix, bin_last,
      output bin_ready
   );
endinterface

// File: rtl/his_rd_fifo.sv
// his_rd_fifo: 2-entry FIFO buffering returned histogram reads.
//   clk, res : clock, asynchronous active-low reset
//   push     : write wdata (caller never pushes when full)
//   pop      : drop the head entry (caller never pops when empty)
//   rdata    : head entry
//   count    : occupancy 0..2
module his_rd_fifo #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         res,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata,
   output logic [1:0]   count
);
   logic [W-1:0] mem_q [2];
   logic         wr_q;
   logic         rd_q;
   logic [1:0]   cnt_q;

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         for (int unsigned i = 0; i < 2; i++) mem_q[i] <= '0;
         wr_q  <= 1'b0;
         rd_q  <= 1'b0;
         cnt_q <= 2'd0;
      end else begin
         if (push) begin
            mem_q[wr_q] <= wdata;
            wr_q        <= ~wr_q;
         end
         if (pop) rd_q <= ~rd_q;
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 2'd1;
            2'b01:   cnt_q <= cnt_q - 2'd1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   assign rdata = mem_q[rd_q];
   assign count = cnt_q;
endmodule

// File: rtl/his_reader.sv
// his_reader: read side of the dToF ping-pong histogram RAM.
// On his_done it reads the finished bank bin by bin for every pixel, streams
// each count over bin_if and reports each pixel's peak bin.
//   clk, res              : clock, asynchronous active-low reset
//   his_done, his_bank    : bank-complete pulse and bank index
//   busy, overrun         : readout active; sticky his_done-while-busy flag
//   ram_rd_*              : RAM read port (data returns one cycle after ram_rd_en)
//   ram_clr_*             : clear-on-read write strobe
//   bin_if (master)       : bin stream to the DF stage
//   peak_*                : per-pixel peak report (peak_valid is a 1-cycle pulse)
// Build option: HIS_READ_CLEAR_EN zeroes each word in the cycle its data
// returns; when undefined ram_clr_en/ram_clr_addr are tied to 0.
module his_reader
   import his_pkg::*;
#(
   parameter int unsigned PIXEL_NUM = 4,
   parameter int unsigned BIN_NUM   = 64,
   parameter int unsigned CNT_W     = 16,
   localparam int unsigned PW = his_idx_w(PIXEL_NUM),
   localparam int unsigned BW = his_idx_w(BIN_NUM),
   localparam int unsigned AW = PW + BW
) (
   input  logic             clk,
   input  logic             res,
   input  logic             his_done,
   input  logic             his_bank,
   output logic             busy,
   output logic             overrun,
   output logic             ram_rd_en,
   output logic             ram_rd_bank,
   output logic [AW-1:0]    ram_rd_addr,
   input  logic [CNT_W-1:0] ram_rd_data,
   output logic             ram_clr_en,
   output logic [AW-1:0]    ram_clr_addr,
   his_reader_if.master     bin_if,
   output logic             peak_valid,
   output logic [PW-1:0]    peak_pix,
   output logic [BW-1:0]    peak_bin,
   output logic [CNT_W-1:0] peak_cnt
);
   localparam int unsigned FW = CNT_W + PW + BW + 1;

   his_rd_state_e    state_q;
   logic             bank_q;
   logic [PW-1:0]    ptr_pix_q;
   logic [BW-1:0]    ptr_bin_q;
   logic             overrun_q;

   // Tag of the read whose data returns this cycle.
   logic             fl_q;
   logic [PW-1:0]    fl_pix_q;
   logic [BW-1:0]    fl_bin_q;
   logic             fl_last_q;

   logic [FW-1:0]    fifo_wdata;
   logic [FW-1:0]    fifo_head;
   logic [1:0]       fifo_cnt;
   logic             pop;
   logic             issue;
   logic             bin_end;
   logic             ptr_end;
   logic [2:0]       occ;

   logic [CNT_W-1:0] max_cnt_q;
   logic [BW-1:0]    max_bin_q;
   logic             take;
   logic [CNT_W-1:0] new_cnt;
   logic [BW-1:0]    new_bin;

   his_rd_fifo #(.W(FW)) u_fifo (
      .clk   (clk),
      .res   (res),
      .push  (fl_q),
      .pop   (pop),
      .wdata (fifo_wdata),
      .rdata (fifo_head),
      .count (fifo_cnt)
   );

   assign fifo_wdata = {ram_rd_data, fl_pix_q, fl_bin_q, fl_last_q};

   assign bin_if.bin_valid = (fifo_cnt != 2'd0);
   assign bin_if.bin_data  = fifo_head[FW-1 -: CNT_W];
   assign bin_if.bin_pix   = fifo_head[BW+1 +: PW];
   assign bin_if.bin_idx   = fifo_head[1 +: BW];
   assign bin_if.bin_last  = fifo_head[0];

   // Issue only if the FIFO can still absorb this read after everything
   // already buffered or in flight, crediting a pop happening this cycle.
   always_comb begin
      pop     = (fifo_cnt != 2'd0) && bin_if.bin_ready;
      occ     = {1'b0, fifo_cnt} + {2'b00, fl_q};
      issue   = (state_q == ST_READ) && (occ <= (3'd1 + {2'b00, pop}));
      bin_end = (ptr_bin_q == BW'(BIN_NUM - 1));
      ptr_end = bin_end && (ptr_pix_q == PW'(PIXEL_NUM - 1));
   end

   assign busy        = (state_q != ST_IDLE);
   assign overrun     = overrun_q;
   assign ram_rd_en   = issue;
   assign ram_rd_bank = bank_q;
   assign ram_rd_addr = issue ? AW'(his_addr(32'(ptr_pix_q), 32'(ptr_bin_q), BW)) : '0;

`ifdef HIS_READ_CLEAR_EN
   assign ram_clr_en   = fl_q;
   assign ram_clr_addr = fl_q ? AW'(his_addr(32'(fl_pix_q), 32'(fl_bin_q), BW)) : '0;
`else
   assign ram_clr_en   = 1'b0;
   assign ram_clr_addr = '0;
`endif

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state_q   <= ST_IDLE;
         bank_q    <= 1'b0;
         ptr_pix_q <= '0;
         ptr_bin_q <= '0;
         overrun_q <= 1'b0;
         fl_q      <= 1'b0;
         fl_pix_q  <= '0;
         fl_bin_q  <= '0;
         fl_last_q <= 1'b0;
      end else begin
         fl_q <= issue;
         if (issue) begin
            fl_pix_q  <= ptr_pix_q;
            fl_bin_q  <= ptr_bin_q;
            fl_last_q <= bin_end;
         end
         if (his_done && (state_q != ST_IDLE)) overrun_q <= 1'b1;
         case (state_q)
            ST_IDLE: begin
               if (his_done) begin
                  state_q   <= ST_READ;
                  bank_q    <= his_bank;
                  ptr_pix_q <= '0;
                  ptr_bin_q <= '0;
               end
            end
            ST_READ: begin
               if (issue) begin
                  if (bin_end) begin
                     ptr_bin_q <= '0;
                     ptr_pix_q <= ptr_pix_q + 1'b1;
                  end else begin
                     ptr_bin_q <= ptr_bin_q + 1'b1;
                  end
                  if (ptr_end) state_q <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               // Leave once the FIFO empties this cycle with nothing returning.
               if (!fl_q && (fifo_cnt == {1'b0, pop})) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Strict compare keeps the lower bin on ties; bin 0 always seeds the max.
   always_comb begin
      take    = pop && ((bin_if.bin_idx == '0) || (bin_if.bin_data > max_cnt_q));
      new_cnt = take ? bin_if.bin_data : max_cnt_q;
      new_bin = take ? bin_if.bin_idx  : max_bin_q;
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         max_cnt_q  <= '0;
         max_bin_q  <= '0;
         peak_valid <= 1'b0;
         peak_pix   <= '0;
         peak_bin   <= '0;
         peak_cnt   <= '0;
      end else begin
         peak_valid <= 1'b0;
         if (pop) begin
            if (bin_if.bin_last) begin
               peak_valid <= 1'b1;
               peak_pix   <= bin_if.bin_pix;
               peak_bin   <= new_bin;
               peak_cnt   <= new_cnt;
               max_cnt_q  <= '0;
               max_bin_q  <= '0;
            end else begin
               max_cnt_q  <= new_cnt;
               max_bin_q  <= new_bin;
            end
         end
      end
   end
endmodule

// File: tb/tb_his_reader.sv
// tb_his_reader: directed bench for his_reader with PIXEL_NUM=2, BIN_NUM=4.
// A behavioural two-bank RAM answers reads one cycle after ram_rd_en and
// honours the clear strobe; a negedge monitor records beats and peaks.
module tb_his_reader;
   localparam int unsigned PN = 2;
   localparam int unsigned BN = 4;
   localparam int unsigned CW = 16;
   localparam int unsigned PW = 1;
   localparam int unsigned BW = 2;
   localparam int unsigned AW = 3;

   logic          clk = 1'b0;
   logic          res = 1'b0;
   logic          his_done = 1'b0;
   logic          his_bank = 1'b0;
   logic          busy, overrun, ram_rd_en, ram_rd_bank, ram_clr_en;
   logic [AW-1:0] ram_rd_addr, ram_clr_addr;
   logic [CW-1:0] ram_rd_data = '0;
   logic          peak_valid;
   logic [PW-1:0] peak_pix;
   logic [BW-1:0] peak_bin;
   logic [CW-1:0] peak_cnt;

   his_reader_if #(.CNT_W(CW), .PIX_W(PW), .BIN_W(BW)) bif ();

   his_reader #(.PIXEL_NUM(PN), .BIN_NUM(BN), .CNT_W(CW)) u_dut (
      .clk          (clk),
      .res          (res),
      .his_done     (his_done),
      .his_bank     (his_bank),
      .busy         (busy),
      .overrun      (overrun),
      .ram_rd_en    (ram_rd_en),
      .ram_rd_bank  (ram_rd_bank),
      .ram_rd_addr  (ram_rd_addr),
      .ram_rd_data  (ram_rd_data),
      .ram_clr_en   (ram_clr_en),
      .ram_clr_addr (ram_clr_addr),
      .bin_if       (bif.master),
      .peak_valid   (peak_valid),
      .peak_pix     (peak_pix),
      .peak_bin     (peak_bin),
      .peak_cnt     (peak_cnt)
   );

   always #5 clk = ~clk;

   // RAM contents: bank0 pix0 {3,9,1,9}, pix1 {0,0,0,0}; bank1 {5,6,7,8},{1,2,3,4}.
   logic [CW-1:0] init0 [8] = '{16'd3, 16'd9, 16'd1, 16'd9, 16'd0, 16'd0, 16'd0, 16'd0};
   logic [CW-1:0] init1 [8] = '{16'd5, 16'd6, 16'd7, 16'd8, 16'd1, 16'd2, 16'd3, 16'd4};
   // Expected peaks {pix, bin, cnt} per bank and pixel.
   logic [PW+BW+CW-1:0] exp_pk [2][2] = '{
      '{{1'b0, 2'd1, 16'd9}, {1'b1, 2'd0, 16'd0}},
      '{{1'b0, 2'd3, 16'd8}, {1'b1, 2'd3, 16'd4}}
   };

   logic [CW-1:0] mem [2][8];
   logic          load_req = 1'b0;

   always @(posedge clk) begin
      if (load_req) begin
         for (int k = 0; k < 8; k++) begin
            mem[0][k] <= init0[k];
            mem[1][k] <= init1[k];
         end
      end else begin
         if (ram_rd_en) ram_rd_data <= mem[ram_rd_bank][ram_rd_addr];
         if (ram_clr_en) mem[ram_rd_bank][ram_clr_addr] <= '0;
      end
   end

   typedef struct packed {
      logic [31:0]   cyc;
      logic [CW-1:0] data;
      logic [PW-1:0] pix;
      logic [BW-1:0] idx;
      logic          last;
   } beat_t;

   typedef struct packed {
      logic [31:0]   cyc;
      logic [PW-1:0] pix;
      logic [BW-1:0] bin;
      logic [CW-1:0] cnt;
   } peak_t;

   beat_t       beats[$];
   peak_t       peaks[$];
   int unsigned cyc = 0;
   int unsigned t0 = 0;
   int unsigned issued = 0, accepted = 0, max_out = 0, unstable = 0, clr_seen = 0;
   logic        mon_clr = 1'b0;
   logic        prev_stall = 1'b0;
   logic [CW+PW+BW:0] prev_bin = '0;
   logic [CW+PW+BW:0] cur_bin;
   logic        hs;

   assign cur_bin = {bif.bin_data, bif.bin_pix, bif.bin_idx, bif.bin_last};
   assign hs      = bif.bin_valid && bif.bin_ready;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (mon_clr) begin
         beats.delete();
         peaks.delete();
         issued <= 0; accepted <= 0; max_out <= 0; unstable <= 0; clr_seen <= 0;
         prev_stall <= 1'b0;
      end else if (!res) begin
         issued <= 0; accepted <= 0;
         prev_stall <= 1'b0;
      end else begin
         if (prev_stall && (cur_bin != prev_bin)) unstable <= unstable + 1;
         prev_stall <= bif.bin_valid && !bif.bin_ready;
         prev_bin   <= cur_bin;
         if (hs) beats.push_back(beat_t'{cyc - t0, bif.bin_data, bif.bin_pix, bif.bin_idx, bif.bin_last});
         if (peak_valid) peaks.push_back(peak_t'{cyc - t0, peak_pix, peak_bin, peak_cnt});
         if (ram_clr_en) clr_seen <= clr_seen + 1;
         if ((issued + 32'(ram_rd_en)) - (accepted + 32'(hs)) > max_out)
            max_out <= (issued + 32'(ram_rd_en)) - (accepted + 32'(hs));
         issued   <= issued + 32'(ram_rd_en);
         accepted <= accepted + 32'(hs);
      end
   end

   int unsigned n_chk = 0;
   int unsigned n_fail = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] outs_vec();
      return 64'({busy, overrun, ram_rd_en, ram_rd_bank, ram_rd_addr, ram_clr_en, ram_clr_addr,
                  bif.bin_valid, bif.bin_data, bif.bin_idx, bif.bin_pix, bif.bin_last,
                  peak_valid, peak_pix, peak_bin, peak_cnt});
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_ram();
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
   endtask

   task automatic clear_mon();
      mon_clr = 1'b1;
      tick();
      mon_clr = 1'b0;
   endtask

   // Called at posedge+1; the current cycle becomes cycle 0 of the readout.
   task automatic start_run(input logic bank);
      his_bank = bank;
      his_done = 1'b1;
      t0 = cyc;
      tick();
      his_done = 1'b0;
   endtask

   task automatic wait_idle(input bit rnd, output int unsigned fall);
      bit done_f = 1'b0;
      fall = 0;
      for (int i = 0; i < 200 && !done_f; i++) begin
         @(negedge clk);
         if (!busy) begin
            done_f = 1'b1;
            fall   = cyc - t0;
         end else begin
            @(posedge clk);
            #1;
            if (rnd) bif.bin_ready = 1'($urandom_range(0, 1));
         end
      end
      if (!done_f) check("busy_timeout", 64'(busy), 64'd0);
      bif.bin_ready = 1'b1;
      tick();
   endtask

   task automatic cmp_run(input int unsigned bank);
      logic [CW-1:0] d;
      check("beat_count", 64'(beats.size()), 64'd8);
      for (int k = 0; k < 8 && k < beats.size(); k++) begin
         d = (bank == 0) ? init0[k] : init1[k];
         check("beat", 64'({beats[k].data, beats[k].pix, beats[k].idx, beats[k].last}),
               64'({d, 1'(k / 4), 2'(k % 4), (k % 4) == 3}));
      end
      check("peak_count", 64'(peaks.size()), 64'd2);
      for (int p = 0; p < 2 && p < peaks.size(); p++)
         check("peak", 64'({peaks[p].pix, peaks[p].bin, peaks[p].cnt}), 64'(exp_pk[bank][p]));
   endtask

   int unsigned fall;
   int unsigned pre_cnt;

   initial begin
      bif.bin_ready = 1'b1;
      repeat (3) tick();
      check("reset_outs", outs_vec(), 64'd0);
      res = 1'b1;
      tick();

      // Bank 0, ready held high: latency, throughput, end timing.
      load_ram();
      clear_mon();
      start_run(1'b0);
      @(negedge clk);
      check("lat_rd_en_c1", 64'(ram_rd_en), 64'd1);
      check("lat_addr_c1", 64'(ram_rd_addr), 64'd0);
      check("lat_bank_c1", 64'(ram_rd_bank), 64'd0);
      tick();
      @(negedge clk);
      check("lat_valid_c2", 64'(bif.bin_valid), 64'd0);
      tick();
      @(negedge clk);
      check("lat_valid_c3", 64'(bif.bin_valid), 64'd1);
      tick();
      wait_idle(1'b0, fall);
      check("busy_fall_cyc", 64'(fall), 64'd11);
      cmp_run(0);
      if (beats.size() == 8) begin
         check("beat_first_cyc", 64'(beats[0].cyc), 64'd3);
         check("beat_last_cyc", 64'(beats[7].cyc), 64'd10);
      end
      if (peaks.size() == 2) begin
         check("peak0_cyc", 64'(peaks[0].cyc), 64'd7);
         check("peak1_cyc", 64'(peaks[1].cyc), 64'd11);
      end
      check("max_out_ready", 64'(max_out > 2), 64'd0);
      check("overrun_clean", 64'(overrun), 64'd0);

      // Bank 0 with forced stall then random backpressure.
      load_ram();
      clear_mon();
      bif.bin_ready = 1'b0;
      start_run(1'b0);
      repeat (5) tick();
      check("stall_issued", 64'(issued), 64'd2);
      check("stall_head", 64'({bif.bin_valid, bif.bin_data}), 64'({1'b1, 16'd3}));
      wait_idle(1'b1, fall);
      cmp_run(0);
      check("max_out_bp", 64'(max_out > 2), 64'd0);
      check("stable_bp", 64'(unstable), 64'd0);

      // his_done during a readout is ignored and flagged.
      load_ram();
      clear_mon();
      start_run(1'b0);
      repeat (4) tick();
      his_bank = 1'b1;
      his_done = 1'b1;
      tick();
      his_done = 1'b0;
      @(negedge clk);
      check("overrun_set", 64'(overrun), 64'd1);
      check("overrun_busy", 64'(busy), 64'd1);
      tick();
      wait_idle(1'b0, fall);
      cmp_run(0);
      check("overrun_sticky", 64'(overrun), 64'd1);

      // Reset after three beats aborts; restart on bank 1.
      load_ram();
      clear_mon();
      start_run(1'b0);
      pre_cnt = 0;
      for (int i = 0; i < 20 && pre_cnt < 3; i++) begin
         @(negedge clk);
         pre_cnt = beats.size();
         tick();
      end
      check("abort_beats", 64'(pre_cnt), 64'd3);
      res = 1'b0;
      #1;
      check("abort_outs", outs_vec(), 64'd0);
      tick();
      tick();
      check("abort_no_peak", 64'(peaks.size()), 64'd0);
      res = 1'b1;
      tick();
      load_ram();
      clear_mon();
      start_run(1'b1);
      @(negedge clk);
      check("restart_rd_en", 64'(ram_rd_en), 64'd1);
      check("restart_addr", 64'(ram_rd_addr), 64'd0);
      check("restart_bank", 64'(ram_rd_bank), 64'd1);
      tick();
      wait_idle(1'b0, fall);
      cmp_run(1);

`ifdef HIS_READ_CLEAR_EN
      for (int k = 0; k < 8; k++) check("cleared_word", 64'(mem[1][k]), 64'd0);
      check("clr_seen", 64'(clr_seen), 64'd8);
`else
      for (int k = 0; k < 8; k++) check("kept_word", 64'(mem[1][k]), 64'(init1[k]));
      check("clr_never", 64'(clr_seen), 64'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
